// File: rtl/forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// forward_hazard_unit
//
// Operand-forwarding and hazard unit placed between decode and execute.
// Each of NUM_SRC source operands is resolved against NUM_FWD forwarding ports.
// Port 0 is the youngest producer (EX), and higher indices are older (MEM, ...).
// A register scoreboard tracks in-flight multi-cycle producers such as
// mul/div/load. The unit raises a combinational stall and keeps a saturating
// count of stalled cycles.
//
// Ports:
//   clk           clock
//   reset         synchronous active-low reset
//   fwd_valid     [NUM_FWD]          forwarding port carries a register write
//   fwd_ready     [NUM_FWD]          forwarding data is final (0 = not yet)
//   fwd_dst       [NUM_FWD*REG_AW]   destination register per port
//   fwd_data      [NUM_FWD*XLEN]     write data per port
//   src_use       [NUM_SRC]          operand is read by the decoded instruction
//   src_rs        [NUM_SRC*REG_AW]   source register per operand
//   src_rf        [NUM_SRC*XLEN]     register-file read data per operand
//   src_out       [NUM_SRC*XLEN]     resolved operand value
//   issue_valid   multi-cycle instruction issues this cycle
//   issue_dst     [REG_AW]           its destination register
//   wb_valid      multi-cycle result written back this cycle
//   wb_dst        [REG_AW]           register written back
//   flush         clears the scoreboard
//   stall         hold decode / bubble execute
//   stall_cycles  [CNT_W]            saturating count of stalled cycles
//   busy_vec      [2**REG_AW]        scoreboard state (debug)
// -----------------------------------------------------------------------------
module forward_hazard_unit #(
   parameter int XLEN    = 64,
   parameter int NUM_SRC = 2,
   parameter int NUM_FWD = 2,
   parameter int REG_AW  = 5,
   parameter int CNT_W   = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_FWD-1:0]         fwd_valid,
   input  logic [NUM_FWD-1:0]         fwd_ready,
   input  logic [NUM_FWD*REG_AW-1:0]  fwd_dst,
   input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
   input  logic [NUM_SRC-1:0]         src_use,
   input  logic [NUM_SRC*REG_AW-1:0]  src_rs,
   input  logic [NUM_SRC*XLEN-1:0]    src_rf,
   output logic [NUM_SRC*XLEN-1:0]    src_out,
   input  logic                       issue_valid,
   input  logic [REG_AW-1:0]          issue_dst,
   input  logic                       wb_valid,
   input  logic [REG_AW-1:0]          wb_dst,
   input  logic                       flush,
   output logic                       stall,
   output logic [CNT_W-1:0]           stall_cycles,
   output logic [(2**REG_AW)-1:0]     busy_vec
);

   localparam int NREG = 2**REG_AW;

   logic [NREG-1:0]           r_busy;
   logic [CNT_W-1:0]          r_stall_cycles;
   logic [NUM_SRC-1:0]        w_hazard;
   logic [NUM_SRC*XLEN-1:0]   w_src_out;
   logic                      w_stall;

   // Per-operand forward select and hazard detection.
   always_comb begin : fwd_select
      logic [REG_AW-1:0] w_rs;
      logic              w_found;
      logic              w_ready;
      logic [XLEN-1:0]   w_data;
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
      w_src_out = src_rf;
      w_hazard  = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         w_rs    = src_rs[j*REG_AW +: REG_AW];
         w_found = 1'b0;
         w_ready = 1'b0;
         w_data  = '0;
         // The first (youngest) matching port wins; older ports never override it.
         for (int i = 0; i < NUM_FWD; i++) begin
            if (!w_found && fwd_valid[i] && (fwd_dst[i*REG_AW +: REG_AW] == w_rs)) begin
               w_found = 1'b1;
               w_ready = fwd_ready[i];
               w_data  = fwd_data[i*XLEN +: XLEN];
            end
         end
         if (src_use[j] && (w_rs != '0)) begin
            if (w_found && w_ready) begin
               w_src_out[j*XLEN +: XLEN] = w_data;
            end else if (w_found) begin
               w_hazard[j] = 1'b1;
            end
            // A ready forward bypasses the scoreboard, which covers a writeback seen on a port.
            if (r_busy[w_rs] && !(w_found && w_ready)) begin
               w_hazard[j] = 1'b1;
            end
         end
      end
   end

   assign w_stall = |w_hazard;

   // Scoreboard and stall counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: only the scoreboard and counter flops need a reset; there is no memory array here.
         r_busy         <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (flush) begin
            r_busy <= '0;
         end else begin
            // NOTE: non-blocking writes to the same bit resolve last-wins, so the set below overrides the clear.
            if (wb_valid && (wb_dst != '0)) begin
               r_busy[wb_dst] <= 1'b0;
            end
            if (issue_valid && !w_stall && (issue_dst != '0)) begin
               r_busy[issue_dst] <= 1'b1;
            end
         end
         if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         end
      end
   end

   assign src_out      = w_src_out;
   assign stall        = w_stall;
   assign stall_cycles = r_stall_cycles;
   assign busy_vec     = {r_busy[NREG-1:1], 1'b0};

endmodule
